mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of a single-ported synchronous memory. Port A is
// the CPU data port, port B the loader/DMA port. Each accepted access either
// strobes the memory for WAIT_CYCLES cycles (aligned) or is completed at once
// with an error (misaligned). Ties are broken round-robin on the last grant.
//
// Handshake (both ports): the requester raises *_req together with *_we,
// *_addr and *_wdata and keeps all four stable until it sees *_ack high on a
// rising edge. *_ack is a one-cycle pulse; *_rdata and *_err are only
// meaningful while *_ack is high. The arbiter samples requests only in IDLE,
// and the IDLE cycle after a completion is a fresh sampling point, so a req
// that is still high there is taken as a new back-to-back request.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  port A request and fields (inputs)
//   a_ack/a_rdata/a_err        port A completion (registered outputs)
//   b_*                        same for port B
//   mem_address/mem_write_data memory address / write data (registered)
//   mem_read/mem_write         memory strobes (registered, mutually exclusive)
//   mem_read_data              memory read data, combinational from memory
//   dbg_state                  current FSM state (IDLE=0, GRANT=1, DONE=2)
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        a_req,
   input  logic        a_we,
   input  logic [17:0] a_addr,
   input  logic [31:0] a_wdata,
   output logic        a_ack,
   output logic [31:0] a_rdata,
   output logic        a_err,

   input  logic        b_req,
   input  logic        b_we,
   input  logic [17:0] b_addr,
   input  logic [31:0] b_wdata,
   output logic        b_ack,
   output logic [31:0] b_rdata,
   output logic        b_err,

   output logic [17:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_read_data,

   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // The counter is loaded with WAIT_CYCLES-1 on entry to GRANT; the GRANT
   // cycle in which it reads zero is the last strobe cycle.
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  wait_cnt, wait_cnt_nxt;
   logic        last_grant, last_grant_nxt;   // 0 = A, 1 = B
   logic        winner, winner_nxt;           // port of the access in flight
   logic        lat_we, lat_we_nxt;

   logic [17:0] mem_address_nxt;
   logic [31:0] mem_write_data_nxt;
   logic        mem_read_nxt, mem_write_nxt;
   logic        a_ack_nxt, b_ack_nxt;
   logic        a_err_nxt, b_err_nxt;
   logic [31:0] a_rdata_nxt, b_rdata_nxt;

   logic        pick_b;
   logic        pick_we;
   logic [17:0] pick_addr;
   logic [31:0] pick_wdata;

   assign dbg_state = state;

   // --------------------------------------------------------------------------
   // State and output registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         wait_cnt       <= 4'd0;
         last_grant     <= 1'b1;   // B, so A wins the first tie
         winner         <= 1'b0;
         lat_we         <= 1'b0;
         mem_address    <= 18'd0;
         mem_write_data <= 32'd0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         a_ack          <= 1'b0;
         b_ack          <= 1'b0;
         a_err          <= 1'b0;
         b_err          <= 1'b0;
         a_rdata        <= 32'd0;
         b_rdata        <= 32'd0;
      end else begin
         state          <= state_nxt;
         wait_cnt       <= wait_cnt_nxt;
         last_grant     <= last_grant_nxt;
         winner         <= winner_nxt;
         lat_we         <= lat_we_nxt;
         mem_address    <= mem_address_nxt;
         mem_write_data <= mem_write_data_nxt;
         mem_read       <= mem_read_nxt;
         mem_write      <= mem_write_nxt;
         a_ack          <= a_ack_nxt;
         b_ack          <= b_ack_nxt;
         a_err          <= a_err_nxt;
         b_err          <= b_err_nxt;
         a_rdata        <= a_rdata_nxt;
         b_rdata        <= b_rdata_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // Arbitration: single requester wins outright; on a tie the port that was
   // not granted last wins.
   // --------------------------------------------------------------------------
   always_comb begin
      pick_b     = b_req & (~a_req | ~last_grant);
      pick_we    = pick_b ? b_we    : a_we;
      pick_addr  = pick_b ? b_addr  : a_addr;
      pick_wdata = pick_b ? b_wdata : a_wdata;
   end

   // --------------------------------------------------------------------------
   // Next-state and next-output logic. Every output register is computed here
   // one cycle ahead, so what leaves the block is always a flop.
   // --------------------------------------------------------------------------
   always_comb begin
      state_nxt          = state;
      wait_cnt_nxt       = wait_cnt;
      last_grant_nxt     = last_grant;
      winner_nxt         = winner;
      lat_we_nxt         = lat_we;
      mem_address_nxt    = mem_address;
      mem_write_data_nxt = mem_write_data;
      mem_read_nxt       = 1'b0;
      mem_write_nxt      = 1'b0;
      a_ack_nxt          = 1'b0;
      b_ack_nxt          = 1'b0;
      a_err_nxt          = 1'b0;
      b_err_nxt          = 1'b0;
      a_rdata_nxt        = a_rdata;
      b_rdata_nxt        = b_rdata;

      case (state)
         IDLE: begin
            if (a_req || b_req) begin
               winner_nxt     = pick_b;
               last_grant_nxt = pick_b;
               lat_we_nxt     = pick_we;
               if (pick_addr[1:0] != 2'b00) begin
                  // Misaligned: skip the memory entirely, complete with error.
                  state_nxt = DONE;
                  if (pick_b) begin
                     b_ack_nxt   = 1'b1;
                     b_err_nxt   = 1'b1;
                     b_rdata_nxt = 32'd0;
                  end else begin
                     a_ack_nxt   = 1'b1;
                     a_err_nxt   = 1'b1;
                     a_rdata_nxt = 32'd0;
                  end
               end else begin
                  state_nxt          = GRANT;
                  wait_cnt_nxt       = WAIT_LOAD;
                  mem_address_nxt    = pick_addr;
                  mem_write_data_nxt = pick_wdata;
                  mem_read_nxt       = ~pick_we;
                  mem_write_nxt      = pick_we;
               end
            end
         end

         GRANT: begin
            if (wait_cnt == 4'd0) begin
               // Last strobe cycle: memory data is valid for the registered
               // address now, so capture it into the winner's read register.
               state_nxt = DONE;
               if (winner) begin
                  b_ack_nxt = 1'b1;
                  if (!lat_we) b_rdata_nxt = mem_read_data;
               end else begin
                  a_ack_nxt = 1'b1;
                  if (!lat_we) a_rdata_nxt = mem_read_data;
               end
            end else begin
               wait_cnt_nxt  = wait_cnt - 4'd1;
               mem_read_nxt  = ~lat_we;
               mem_write_nxt = lat_we;
            end
         end

         DONE: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiter instances: dut1 with WAIT_CYCLES=1 (scoreboarded: expected acks
// and expected memory strobes are queued by the stimulus, a negedge monitor
// pops and compares), and dut3 with WAIT_CYCLES=3 (strobe length and reset
// during GRANT, checked inline against hand-computed cycle positions).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1 = 1'b0;
   logic rst3 = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;

   // ---------------------------------------------------------------- dut1 (W=1)
   logic        a_req = 0, a_we = 0;
   logic [17:0] a_addr = 0;
   logic [31:0] a_wdata = 0;
   logic        a_ack, a_err;
   logic [31:0] a_rdata;
   logic        b_req = 0, b_we = 0;
   logic [17:0] b_addr = 0;
   logic [31:0] b_wdata = 0;
   logic        b_ack, b_err;
   logic [31:0] b_rdata;
   logic [17:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_read, mem_write;
   logic [31:0] mem_read_data;
   logic [1:0]  dbg_state;

   // Read-only memory contents, fixed so read results are known by hand.
   function automatic logic [31:0] rom(input logic [17:0] addr);
      case (addr[5:2])
         4'd1:    rom = 32'h1111_0001;
         4'd2:    rom = 32'hCAFE_F00D;
         4'd3:    rom = 32'h3333_0003;
         4'd4:    rom = 32'hDEAD_BEEF;
         4'd5:    rom = 32'h5555_0005;
         default: rom = 32'h0000_0000;
      endcase
   endfunction

   assign mem_read_data = rom(mem_address);

   mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst1),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_read_data(mem_read_data), .dbg_state(dbg_state)
   );

   // ---------------------------------------------------------------- dut3 (W=3)
   logic        p_a_req = 0, p_a_we = 0;
   logic [17:0] p_a_addr = 0;
   logic [31:0] p_a_wdata = 0;
   logic        p_a_ack, p_a_err;
   logic [31:0] p_a_rdata;
   logic        p_b_req = 0, p_b_we = 0;
   logic [17:0] p_b_addr = 0;
   logic [31:0] p_b_wdata = 0;
   logic        p_b_ack, p_b_err;
   logic [31:0] p_b_rdata;
   logic [17:0] p_mem_address;
   logic [31:0] p_mem_write_data;
   logic        p_mem_read, p_mem_write;
   logic [31:0] p_mem_read_data = 32'h0;
   logic [1:0]  p_dbg_state;

   mem_arbiter #(.WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst3),
      .a_req(p_a_req), .a_we(p_a_we), .a_addr(p_a_addr), .a_wdata(p_a_wdata),
      .a_ack(p_a_ack), .a_rdata(p_a_rdata), .a_err(p_a_err),
      .b_req(p_b_req), .b_we(p_b_we), .b_addr(p_b_addr), .b_wdata(p_b_wdata),
      .b_ack(p_b_ack), .b_rdata(p_b_rdata), .b_err(p_b_err),
      .mem_address(p_mem_address), .mem_write_data(p_mem_write_data),
      .mem_read(p_mem_read), .mem_write(p_mem_write),
      .mem_read_data(p_mem_read_data), .dbg_state(p_dbg_state)
   );

   // ---------------------------------------------------------------- checker
   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- scoreboard
   // ack entry: {port(1=B), err, rdata}
   logic [33:0] exp_q[$];
   // strobe entry: {we, addr, wdata}
   logic [50:0] str_q[$];

   task automatic expect_ack(input logic port_b, input logic err,
                             input logic [31:0] rdata);
      exp_q.push_back({port_b, err, rdata});
   endtask

   task automatic expect_strobe(input logic we, input logic [17:0] addr,
                                input logic [31:0] wdata);
      str_q.push_back({we, addr, wdata});
   endtask

   logic        str_prev = 1'b0;
   logic        ack_prev = 1'b0;
   int          run_len = 0;
   logic [17:0] run_addr;
   logic [31:0] run_data;
   logic        run_we;
   logic [33:0] ack_e;
   logic [50:0] str_e;

   always @(negedge clk) begin
      if (!rst1) begin
         // memory strobe monitor
         if (mem_read || mem_write) begin
            check("strobe_exclusive", {63'd0, mem_read & mem_write}, 64'd0);
            if (!str_prev) begin
               if (str_q.size() == 0) begin
                  check("strobe_unexpected", 64'd1, 64'd0);
               end else begin
                  str_e = str_q.pop_front();
                  check("strobe_we", {63'd0, mem_write}, {63'd0, str_e[50]});
                  check("strobe_addr", {46'd0, mem_address}, {46'd0, str_e[49:32]});
                  if (str_e[50])
                     check("strobe_wdata", {32'd0, mem_write_data}, {32'd0, str_e[31:0]});
               end
               run_len  = 1;
               run_addr = mem_address;
               run_data = mem_write_data;
               run_we   = mem_write;
            end else begin
               run_len++;
               check("strobe_stable", {13'd0, mem_address, mem_write_data, mem_write},
                     {13'd0, run_addr, run_data, run_we});
            end
         end else if (str_prev) begin
            check("strobe_len", 64'(run_len), 64'd1);
         end
         str_prev = mem_read | mem_write;

         // ack monitor
         if (a_ack || b_ack) begin
            check("ack_onehot", {63'd0, a_ack & b_ack}, 64'd0);
            check("ack_pulse", {63'd0, ack_prev}, 64'd0);
            if (exp_q.size() == 0) begin
               check("ack_unexpected", 64'd1, 64'd0);
            end else begin
               ack_e = exp_q.pop_front();
               check("ack_port", {63'd0, b_ack}, {63'd0, ack_e[33]});
               check("ack_err", {63'd0, (b_ack ? b_err : a_err)}, {63'd0, ack_e[32]});
               check("ack_rdata", {32'd0, (b_ack ? b_rdata : a_rdata)},
                     {32'd0, ack_e[31:0]});
            end
         end
         ack_prev = a_ack | b_ack;
      end
   end

   // ---------------------------------------------------------------- drivers
   // Raise req just after a rising edge, hold until ack seen, release after
   // the next rising edge. lat is the negedge count from raise to ack
   // (0 = do not check).
   task automatic drive_a(input logic we, input logic [17:0] addr,
                          input logic [31:0] wdata, input int lat);
      int cyc;
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!a_ack && cyc < 100);
      if (!a_ack) check("a_ack_timeout", 64'd1, 64'd0);
      else if (lat != 0) check("a_latency", 64'(cyc), 64'(lat));
      @(posedge clk);
      #1;
      a_req = 1'b0;
   endtask

   task automatic drive_b(input logic we, input logic [17:0] addr,
                          input logic [31:0] wdata, input int lat);
      int cyc;
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!b_ack && cyc < 100);
      if (!b_ack) check("b_ack_timeout", 64'd1, 64'd0);
      else if (lat != 0) check("b_latency", 64'(cyc), 64'(lat));
      @(posedge clk);
      #1;
      b_req = 1'b0;
   endtask

   task automatic reset_dut1();
      @(posedge clk);
      #1;
      rst1 = 1'b1;
      @(posedge clk);
      #1;
      rst1 = 1'b0;
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- stimulus
   int ack_seen;

   initial begin
      // Reset is asserted between clock edges: outputs must clear at once.
      #1;
      rst1 = 1'b1;
      rst3 = 1'b1;
      #1;
      check("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
      check("rst_mem_addr", {46'd0, mem_address}, 64'd0);
      check("rst_mem_wdata", {32'd0, mem_write_data}, 64'd0);
      check("rst_acks_errs", {60'd0, a_ack, b_ack, a_err, b_err}, 64'd0);
      check("rst_rdata", {a_rdata, b_rdata}, 64'd0);
      check("rst_state", {62'd0, dbg_state}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst1 = 1'b0;
      rst3 = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Single aligned A read.
      expect_strobe(1'b0, 18'h00010, 32'h0);
      expect_ack(1'b0, 1'b0, 32'hDEAD_BEEF);
      drive_a(1'b0, 18'h00010, 32'h0, 3);

      // Simultaneous A write / B read straight after reset: A first.
      reset_dut1();
      expect_strobe(1'b1, 18'h00004, 32'h1234_5678);
      expect_strobe(1'b0, 18'h00008, 32'h0);
      expect_ack(1'b0, 1'b0, 32'h0000_0000);       // write: rdata holds reset value
      expect_ack(1'b1, 1'b0, 32'hCAFE_F00D);
      fork
         drive_a(1'b1, 18'h00004, 32'h1234_5678, 0);
         drive_b(1'b0, 18'h00008, 32'h0, 0);
      join

      // Both ports request continuously: strict A,B alternation (B was last).
      expect_strobe(1'b0, 18'h00010, 32'h0);
      expect_strobe(1'b0, 18'h00004, 32'h0);
      expect_strobe(1'b1, 18'h00014, 32'hA5A5_0001);
      expect_strobe(1'b0, 18'h0000C, 32'h0);
      expect_strobe(1'b0, 18'h00014, 32'h0);
      expect_strobe(1'b1, 18'h00020, 32'h5A5A_0002);
      expect_ack(1'b0, 1'b0, 32'hDEAD_BEEF);
      expect_ack(1'b1, 1'b0, 32'h1111_0001);
      expect_ack(1'b0, 1'b0, 32'hDEAD_BEEF);       // write holds previous
      expect_ack(1'b1, 1'b0, 32'h3333_0003);
      expect_ack(1'b0, 1'b0, 32'h5555_0005);
      expect_ack(1'b1, 1'b0, 32'h3333_0003);       // write holds previous
      fork
         begin
            drive_a(1'b0, 18'h00010, 32'h0, 0);
            drive_a(1'b1, 18'h00014, 32'hA5A5_0001, 0);
            drive_a(1'b0, 18'h00014, 32'h0, 0);
         end
         begin
            drive_b(1'b0, 18'h00004, 32'h0, 0);
            drive_b(1'b0, 18'h0000C, 32'h0, 0);
            drive_b(1'b1, 18'h00020, 32'h5A5A_0002, 0);
         end
      join

      // Misaligned B read, then an aligned B read.
      expect_ack(1'b1, 1'b1, 32'h0000_0000);
      drive_b(1'b0, 18'h00006, 32'h0, 2);
      expect_strobe(1'b0, 18'h00008, 32'h0);
      expect_ack(1'b1, 1'b0, 32'hCAFE_F00D);
      drive_b(1'b0, 18'h00008, 32'h0, 3);

      repeat (3) @(posedge clk);
      check("ack_queue_drained", 64'(exp_q.size()), 64'd0);
      check("strobe_queue_drained", 64'(str_q.size()), 64'd0);

      // ---- dut3: write interrupted by reset during the 2nd GRANT cycle.
      @(posedge clk);
      #1;
      p_a_req = 1'b1; p_a_we = 1'b1; p_a_addr = 18'h0000C; p_a_wdata = 32'h0BAD_F00D;
      @(negedge clk);   // not yet sampled
      check("w3_pre_strobe", {63'd0, p_mem_write}, 64'd0);
      @(negedge clk);   // 1st GRANT cycle
      check("w3_int_strobe1", {63'd0, p_mem_write}, 64'd1);
      @(negedge clk);   // 2nd GRANT cycle
      check("w3_int_strobe2", {63'd0, p_mem_write}, 64'd1);
      #2;
      rst3 = 1'b1;
      p_a_req = 1'b0;
      #1;
      check("w3_rst_strobe_drop", {62'd0, p_mem_write, p_mem_read}, 64'd0);
      check("w3_rst_no_ack", {62'd0, p_a_ack, p_a_err}, 64'd0);
      check("w3_rst_state", {62'd0, p_dbg_state}, 64'd0);
      @(posedge clk);
      #1;
      rst3 = 1'b0;
      ack_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (p_a_ack || p_b_ack || p_mem_write || p_mem_read) ack_seen++;
      end
      check("w3_discarded_access", 64'(ack_seen), 64'd0);

      // ---- dut3: uninterrupted write, strobe exactly 3 cycles.
      @(posedge clk);
      #1;
      p_a_req = 1'b1; p_a_we = 1'b1; p_a_addr = 18'h00010; p_a_wdata = 32'hFEED_FACE;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         check($sformatf("w3_strobe_c%0d", c), {62'd0, p_mem_write, p_mem_read},
               {62'd0, (c >= 2 && c <= 4), 1'b0});
         if (c >= 2 && c <= 4)
            check($sformatf("w3_addr_data_c%0d", c), {14'd0, p_mem_address, p_mem_write_data},
                  {14'd0, 18'h00010, 32'hFEED_FACE});
         check($sformatf("w3_ack_c%0d", c), {63'd0, p_a_ack}, {63'd0, (c == 5)});
         if (c == 5) begin
            check("w3_ack_err", {63'd0, p_a_err}, 64'd0);
            check("w3_ack_rdata", {32'd0, p_a_rdata}, 64'd0);
            @(posedge clk);
            #1;
            p_a_req = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
